// File: rtl/diff_io_pkg.sv
// Shared types and defaults for the half-duplex differential link endpoint.
package diff_io_pkg;
   localparam int DEF_DATA_WIDTH     = 26;
   localparam int DEF_CYCLES_PER_BIT = 8;

   typedef enum logic [1:0] {MODE_IDLE, MODE_TX, MODE_RX} mode_t;
   typedef enum logic [1:0] {TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/diff_io_rx.sv
// Receive path: line synchroniser, start-bit detect, mid-bit sampler and
// payload shift register. Emits the framed word with a one-cycle strobe.
module diff_io_rx import diff_io_pkg::*; #(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int CYCLES_PER_BIT = DEF_CYCLES_PER_BIT
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  en,
   input  logic                  line,
   output logic                  start,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  valid
);
   localparam int TW = $clog2(CYCLES_PER_BIT);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [TW-1:0] BIT_LAST  = TW'(CYCLES_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(CYCLES_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] CNT_LAST  = BW'(DATA_WIDTH - 1);

   rx_state_t             state;
   logic [2:0]            sync_q;
   logic [TW-1:0]         timer;
   logic [BW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] shift;
   logic                  rx_bit;
   logic                  tick;

   // sync_q[1:0] is the two-flop synchroniser; sync_q[2] is only edge history
   assign rx_bit = sync_q[1];
   assign tick   = (timer == '0);
   assign start  = en && (state == RX_IDLE) && sync_q[2] && !sync_q[1];
   assign done   = tick && (((state == RX_START) && rx_bit) || (state == RX_STOP));

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sync_q <= 3'b111;
         state  <= RX_IDLE;
         timer  <= '0;
         cnt    <= '0;
         shift  <= '0;
         word   <= '0;
         valid  <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], line};
         valid  <= 1'b0;
         if (!en) begin
            state <= RX_IDLE;
         end else begin
            case (state)
               RX_IDLE: if (start) begin
                  state <= RX_START;
                  timer <= HALF_LAST;
               end
               RX_START: if (!tick) begin
                  timer <= timer - TW'(1);
               end else if (rx_bit) begin
                  state <= RX_IDLE;
               end else begin
                  state <= RX_DATA;
                  timer <= BIT_LAST;
                  cnt   <= CNT_LAST;
               end
               RX_DATA: if (!tick) begin
                  timer <= timer - TW'(1);
               end else begin
                  shift <= {shift[DATA_WIDTH-2:0], rx_bit};
                  timer <= BIT_LAST;
                  if (cnt == '0) state <= RX_STOP;
                  else           cnt   <= cnt - BW'(1);
               end
               RX_STOP: if (!tick) begin
                  timer <= timer - TW'(1);
               end else begin
                  state <= RX_IDLE;
                  // a low stop bit is a framing error: the word is dropped
                  if (rx_bit) begin
                     word  <= shift;
                     valid <= 1'b1;
                  end
               end
               default: state <= RX_IDLE;
            endcase
         end
      end
   end
endmodule

// File: rtl/diff_io_link.sv
// Half-duplex serial endpoint: mode FSM and TX shifter over one differential
// pair, with io_sel steering the external tristate buffer.
module diff_io_link import diff_io_pkg::*; #(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int CYCLES_PER_BIT = DEF_CYCLES_PER_BIT
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  trigger_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  diff_data_in,
   output logic                  diff_data_out,
   output logic                  io_sel,
   output logic                  new_code_out,
   output logic [DATA_WIDTH-1:0] code_out
);
   localparam int TW = $clog2(CYCLES_PER_BIT);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [TW-1:0] BIT_LAST = TW'(CYCLES_PER_BIT - 1);
   localparam logic [BW-1:0] CNT_LAST = BW'(DATA_WIDTH - 1);

   mode_t                 mode;
   tx_state_t             tx_state;
   logic [TW-1:0]         tx_timer;
   logic [BW-1:0]         tx_cnt;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic                  rx_en, rx_start, rx_done, rx_valid;
   logic [DATA_WIDTH-1:0] rx_word;

   // a trigger in IDLE beats a simultaneous start edge; RX is deaf during TX
   assign rx_en = (mode == MODE_RX) || ((mode == MODE_IDLE) && !trigger_in);

   diff_io_rx #(
      .DATA_WIDTH     (DATA_WIDTH),
      .CYCLES_PER_BIT (CYCLES_PER_BIT)
   ) u_rx (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .en     (rx_en),
      .line   (diff_data_in),
      .start  (rx_start),
      .done   (rx_done),
      .word   (rx_word),
      .valid  (rx_valid)
   );

   assign new_code_out = rx_valid;
   assign code_out     = rx_word;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         mode          <= MODE_IDLE;
         tx_state      <= TX_START;
         tx_timer      <= '0;
         tx_cnt        <= '0;
         tx_shift      <= '0;
         diff_data_out <= 1'b1;
         io_sel        <= 1'b0;
      end else begin
         case (mode)
            MODE_IDLE: if (trigger_in) begin
               tx_shift      <= data_in;
               tx_timer      <= BIT_LAST;
               tx_state      <= TX_START;
               diff_data_out <= 1'b0;
               io_sel        <= 1'b1;
               mode          <= MODE_TX;
            end else if (rx_start) begin
               mode <= MODE_RX;
            end
            MODE_TX: if (tx_timer != '0) begin
               tx_timer <= tx_timer - TW'(1);
            end else begin
               tx_timer <= BIT_LAST;
               case (tx_state)
                  TX_START: begin
                     diff_data_out <= tx_shift[DATA_WIDTH-1];
                     tx_shift      <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                     tx_cnt        <= CNT_LAST;
                     tx_state      <= TX_DATA;
                  end
                  TX_DATA: if (tx_cnt == '0) begin
                     diff_data_out <= 1'b1;
                     tx_state      <= TX_STOP;
                  end else begin
                     diff_data_out <= tx_shift[DATA_WIDTH-1];
                     tx_shift      <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                     tx_cnt        <= tx_cnt - BW'(1);
                  end
                  TX_STOP: begin
                     io_sel   <= 1'b0;
                     tx_state <= TX_START;
                     mode     <= MODE_IDLE;
                  end
                  default: tx_state <= TX_START;
               endcase
            end
            MODE_RX: if (rx_done) mode <= MODE_IDLE;
            default: mode <= MODE_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_diff_io_link.sv
// Two cross-connected endpoints exercised with directed transfers, collisions,
// a line glitch and a mid-frame reset.
module tb_diff_io_link;
   localparam int DW = 26;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          trig_a = 1'b0, trig_b = 1'b0;
   logic [DW-1:0] data_a = '0, data_b = '0;
   logic          inj_a = 1'b1, inj_b = 1'b1;
   logic          a_out, b_out, a_sel, b_sel, a_new, b_new, a_in, b_in;
   logic [DW-1:0] a_code, b_code;

   int total = 0, bad = 0;
   int a_strb, b_strb, a_selc, b_selc;
   logic clr = 1'b0;

   always #5 clk = ~clk;

   assign a_in = b_out & inj_a;
   assign b_in = a_out & inj_b;

   diff_io_link #(.DATA_WIDTH(DW), .CYCLES_PER_BIT(8)) u_a (
      .clk_in(clk), .rst_in(rst), .trigger_in(trig_a), .data_in(data_a),
      .diff_data_in(a_in), .diff_data_out(a_out), .io_sel(a_sel),
      .new_code_out(a_new), .code_out(a_code));

   diff_io_link #(.DATA_WIDTH(DW), .CYCLES_PER_BIT(8)) u_b (
      .clk_in(clk), .rst_in(rst), .trigger_in(trig_b), .data_in(data_b),
      .diff_data_in(b_in), .diff_data_out(b_out), .io_sel(b_sel),
      .new_code_out(b_new), .code_out(b_code));

   always @(negedge clk) begin
      if (clr) begin
         a_strb = 0; b_strb = 0; a_selc = 0; b_selc = 0;
      end else begin
         if (a_new) a_strb = a_strb + 1;
         if (b_new) b_strb = b_strb + 1;
         if (a_sel) a_selc = a_selc + 1;
         if (b_sel) b_selc = b_selc + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_cnt();
      @(posedge clk); clr = 1'b1;
      @(posedge clk); clr = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_a(input logic [DW-1:0] d);
      trig_a = 1'b1; data_a = d;
      wait_cyc(1);
      trig_a = 1'b0;
   endtask

   initial begin
      wait_cyc(3);
      chk("rst_a_out", a_out, 1); chk("rst_a_sel", a_sel, 0);
      chk("rst_a_new", a_new, 0); chk("rst_a_code", a_code, 0);
      chk("rst_b_out", b_out, 1); chk("rst_b_code", b_code, 0);
      rst = 1'b0;
      wait_cyc(5);

      // A -> B with frame timing probes
      clear_cnt();
      send_a(26'h0BE3219);
      chk("tx_sel_k1", a_sel, 1); chk("tx_start_k1", a_out, 0);
      wait_cyc(23); chk("tx_bit24", a_out, 0);
      wait_cyc(1);  chk("tx_bit23", a_out, 1);
      wait_cyc(240);
      chk("ab_code", b_code, 26'h0BE3219); chk("ab_bstrb", b_strb, 1);
      chk("ab_asel", a_selc, 224); chk("ab_bsel", b_selc, 0);
      chk("ab_astrb", a_strb, 0);

      // B -> A
      wait_cyc(300);
      clear_cnt();
      trig_b = 1'b1; data_b = 26'h2ADBEEF;
      wait_cyc(1); trig_b = 1'b0;
      wait_cyc(260);
      chk("ba_code", a_code, 26'h2ADBEEF); chk("ba_astrb", a_strb, 1);
      chk("ba_bcode", b_code, 26'h0BE3219); chk("ba_bstrb", b_strb, 0);
      chk("ba_bsel", b_selc, 224); chk("ba_asel", a_selc, 0);

      // retrigger during own TX is dropped
      wait_cyc(20);
      clear_cnt();
      send_a(26'h1234567);
      wait_cyc(49);
      send_a(26'h0000001);
      wait_cyc(560);
      chk("retx_asel", a_selc, 224); chk("retx_bstrb", b_strb, 1);
      chk("retx_bcode", b_code, 26'h1234567);

      // trigger on B while receiving is dropped
      clear_cnt();
      send_a(26'h155AA33);
      wait_cyc(60);
      trig_b = 1'b1; data_b = 26'h3000000;
      wait_cyc(1); trig_b = 1'b0;
      wait_cyc(260);
      chk("rxtrg_bcode", b_code, 26'h155AA33); chk("rxtrg_bstrb", b_strb, 1);
      chk("rxtrg_bsel", b_selc, 0); chk("rxtrg_acode", a_code, 26'h2ADBEEF);
      chk("rxtrg_astrb", a_strb, 0);

      // 3-cycle low glitch on idle line
      clear_cnt();
      inj_b = 1'b0; wait_cyc(3); inj_b = 1'b1;
      wait_cyc(100);
      chk("glitch_bstrb", b_strb, 0); chk("glitch_bcode", b_code, 26'h155AA33);

      // reset 100 cycles into a frame
      clear_cnt();
      send_a(26'h0F0F0F0);
      wait_cyc(99);
      rst = 1'b1;
      wait_cyc(1);
      chk("mrst_a_out", a_out, 1); chk("mrst_a_sel", a_sel, 0);
      chk("mrst_b_code", b_code, 0); chk("mrst_a_code", a_code, 0);
      chk("mrst_b_new", b_new, 0);
      wait_cyc(2);
      rst = 1'b0;
      wait_cyc(300);
      chk("mrst_bstrb", b_strb, 0); chk("mrst_astrb", a_strb, 0);
      clear_cnt();
      send_a(26'h3FFFFFF);
      wait_cyc(260);
      chk("post_bcode", b_code, 26'h3FFFFFF); chk("post_bstrb", b_strb, 1);
      chk("post_asel", a_selc, 224);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
